// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register selectors, ERET funct code, FSM encoding.
package cp0_pkg;

  // CP0 register selectors (instruction bits [13:11])
  localparam logic [2:0] SEL_EPC     = 3'd0;
  localparam logic [2:0] SEL_STATUS  = 3'd1;
  localparam logic [2:0] SEL_MASK    = 3'd2;
  localparam logic [2:0] SEL_CAUSE   = 3'd3;
  localparam logic [2:0] SEL_PENDING = 3'd4;

  // Funct field that identifies ERET
  localparam logic [5:0] FUNCT_ERET = 6'b011000;

  // Exception sequencing states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TAKE    = 2'd1,
    ST_HANDLER = 2'd2
  } cp0_state_e;

endpackage

// File: rtl/cp0_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag.
module cp0_prio_enc #(
  parameter int NUM_SRC = 8,
  parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  // Scan from the top down so the lowest set bit is the last assignment and wins.
  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: edge-captured sticky sources, mask, fixed
// priority, vectored entry, EPC/STATUS/CAUSE registers and MTC0/MFC0/ERET decode.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter int                NUM_SRC    = 8,
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] VEC_BASE   = 32'h0000_0080,
  parameter logic [DATA_W-1:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [31:0]        inst,
  input  logic [DATA_W-1:0]  din,
  input  logic [DATA_W-1:0]  pc_in,
  input  logic [NUM_SRC-1:0] exp_src,
  output logic               is_eret,
  output logic               ex_reg_write,
  output logic               has_exp,
  output logic               exp_block,
  output logic [DATA_W-1:0]  exc_vector,
  output logic [DATA_W-1:0]  pc_out,
  output logic [DATA_W-1:0]  dout
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  // Instruction decode
  logic [2:0] sel;
  logic       cp0_we;
  logic       eret_fire;

  assign is_eret      = (inst[5:0] == FUNCT_ERET);
  assign ex_reg_write = ~inst[23];
  assign sel          = inst[13:11];
  assign cp0_we       = enable & inst[23] & ~is_eret;
  assign eret_fire    = enable & is_eret;

  // Instruction and data bits this block does not look at
  logic unused_bits;
  assign unused_bits = ^{inst[31:24], inst[22:14], inst[10:6], din[DATA_W-1:NUM_SRC]};

  // Architectural state
  cp0_state_e        state_q, state_d;
  logic [DATA_W-1:0] epc_q, epc_d;
  logic [DATA_W-1:0] status_q, status_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] cause_q, cause_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] src_q;
  logic              has_exp_q;
  logic [DATA_W-1:0] vec_q, vec_d;

  // Eligibility and priority selection
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] clr;
  logic [IDX_W-1:0]   idx;
  logic               elig_valid;
  logic               take;

  assign rise = exp_src & ~src_q;
  assign elig = pend_q & ~mask_q;

  cp0_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_prio (
    .req_i   (elig),
    .idx_o   (idx),
    .valid_o (elig_valid)
  );

  // FSM next state; a take is only decided in IDLE, with EXL clear and no ERET this cycle.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (elig_valid && !status_q[0] && !eret_fire) begin
          take    = 1'b1;
          state_d = ST_TAKE;
        end
      end
      ST_TAKE:    state_d = ST_HANDLER;
      ST_HANDLER: if (eret_fire) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Register next values; a take overrides a same-cycle MTC0 to EPC or STATUS.
  always_comb begin
    epc_d    = epc_q;
    status_d = status_q;
    mask_d   = mask_q;
    cause_d  = cause_q;
    vec_d    = vec_q;
    clr      = '0;

    if (take) begin
      epc_d          = pc_in;
      status_d[0]    = 1'b1;
      cause_d        = '0;
      cause_d[DATA_W-1] = 1'b1;
      cause_d[4:0]   = 5'(idx);
      clr            = NUM_SRC'(1) << idx;
      vec_d          = VEC_BASE + DATA_W'(idx) * VEC_STRIDE;
    end else begin
      if (cp0_we && sel == SEL_EPC)    epc_d    = din;
      if (cp0_we && sel == SEL_STATUS) status_d = din;
      if (eret_fire)                   status_d[0] = 1'b0;
    end

    if (cp0_we && sel == SEL_MASK) mask_d = din[NUM_SRC-1:0];

    // A new rising edge sets its bit even if the same bit is being cleared.
    pend_d = (pend_q & ~clr) | rise;
  end

  // CP0 read mux; unimplemented selectors read as zero.
  always_comb begin
    dout = '0;
    case (sel)
      SEL_EPC:     dout = epc_q;
      SEL_STATUS:  dout = status_q;
      SEL_MASK:    dout = DATA_W'(mask_q);
      SEL_CAUSE:   dout = cause_q;
      SEL_PENDING: dout = DATA_W'(pend_q);
      default:     dout = '0;
    endcase
  end

  // State registers with asynchronous reset that also drops every pending bit.
  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      epc_q     <= '0;
      status_q  <= '0;
      mask_q    <= '0;
      cause_q   <= '0;
      pend_q    <= '0;
      src_q     <= '0;
      has_exp_q <= 1'b0;
      vec_q     <= '0;
    end else begin
      state_q   <= state_d;
      epc_q     <= epc_d;
      status_q  <= status_d;
      mask_q    <= mask_d;
      cause_q   <= cause_d;
      pend_q    <= pend_d;
      src_q     <= exp_src;
      has_exp_q <= take;
      vec_q     <= vec_d;
    end
  end

  assign has_exp    = has_exp_q;
  assign exp_block  = status_q[0];
  assign exc_vector = vec_q;
  assign pc_out     = epc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed self-checking bench for cp0_exc_ctrl (NUM_SRC=8, DATA_W=32).
module tb_cp0_exc_ctrl;

  localparam logic [31:0] ERET_INST = 32'h0000_0018;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] inst = '0;
  logic [31:0] din = '0;
  logic [31:0] pc_in = '0;
  logic [7:0]  exp_src = '0;
  logic        is_eret, ex_reg_write, has_exp, exp_block;
  logic [31:0] exc_vector, pc_out, dout;

  int checks = 0;
  int failures = 0;

  cp0_exc_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .inst         (inst),
    .din          (din),
    .pc_in        (pc_in),
    .exp_src      (exp_src),
    .is_eret      (is_eret),
    .ex_reg_write (ex_reg_write),
    .has_exp      (has_exp),
    .exp_block    (exp_block),
    .exc_vector   (exc_vector),
    .pc_out       (pc_out),
    .dout         (dout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1ns past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // MFC0 read of a CP0 register, checked against an expected value (1ns)
  task automatic rd(input logic [2:0] sel, input logic [31:0] exp, input string tag);
    inst   = {18'd0, sel, 11'd0};
    enable = 1'b1;
    #1;
    chk(tag, dout, exp);
    enable = 1'b0;
    inst   = '0;
  endtask

  // MTC0 write lasting one clock edge
  task automatic wr(input logic [2:0] sel, input logic [31:0] data);
    inst   = 32'h0080_0000 | {18'd0, sel, 11'd0};
    din    = data;
    enable = 1'b1;
    step();
    enable = 1'b0;
    inst   = '0;
    din    = '0;
  endtask

  task automatic eret();
    inst   = ERET_INST;
    enable = 1'b1;
    step();
    enable = 1'b0;
    inst   = '0;
  endtask

  initial begin
    // ---- 1a: power-on reset state ----
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    step();
    chk("rst_has_exp", {31'd0, has_exp}, 32'd0);
    chk("rst_exl", {31'd0, exp_block}, 32'd0);
    chk("rst_vec", exc_vector, 32'd0);
    rd(3'd0, 32'd0, "rst_epc");
    rd(3'd1, 32'd0, "rst_status");
    rd(3'd2, 32'd0, "rst_mask");
    rd(3'd3, 32'd0, "rst_cause");
    rd(3'd4, 32'd0, "rst_pending");

    // decode outputs
    inst = ERET_INST;
    #1;
    chk("dec_eret", {31'd0, is_eret}, 32'd1);
    chk("dec_eret_rw", {31'd0, ex_reg_write}, 32'd1);
    inst = 32'h0080_0800;
    #1;
    chk("dec_mtc0_eret", {31'd0, is_eret}, 32'd0);
    chk("dec_mtc0_rw", {31'd0, ex_reg_write}, 32'd0);
    inst = '0;

    // unimplemented selector ignores writes
    wr(3'd5, 32'hFFFF_FFFF);
    rd(3'd5, 32'd0, "sel5_read");

    // ---- 2: single source 3 ----
    pc_in   = 32'h400;
    exp_src = 8'h08;
    step();
    chk("t2_has_exp_k", {31'd0, has_exp}, 32'd0);
    rd(3'd4, 32'h08, "t2_pending_k");
    step();
    chk("t2_has_exp", {31'd0, has_exp}, 32'd1);
    chk("t2_vec", exc_vector, 32'h0000_00B0);
    chk("t2_epc", pc_out, 32'h400);
    chk("t2_exl", {31'd0, exp_block}, 32'd1);
    rd(3'd3, 32'h8000_0003, "t2_cause");
    rd(3'd4, 32'h0, "t2_pending_clr");
    step();
    chk("t2_has_exp_pulse", {31'd0, has_exp}, 32'd0);
    eret();
    chk("t2_exl_after_eret", {31'd0, exp_block}, 32'd0);
    step();
    step();
    chk("t2_held_no_retake", {31'd0, has_exp}, 32'd0);
    exp_src = 8'h00;
    step();

    // ---- 3: simultaneous sources 5 and 2 ----
    exp_src = 8'h24;
    step();
    step();
    chk("t3_has_exp", {31'd0, has_exp}, 32'd1);
    chk("t3_vec", exc_vector, 32'h0000_00A0);
    step();
    rd(3'd3, 32'h8000_0002, "t3_cause");
    rd(3'd4, 32'h20, "t3_pending_ret");
    eret();
    chk("t3_eret_no_take", {31'd0, has_exp}, 32'd0);
    step();
    chk("t3_second_take", {31'd0, has_exp}, 32'd1);
    chk("t3_vec2", exc_vector, 32'h0000_00D0);
    step();
    rd(3'd3, 32'h8000_0005, "t3_cause2");
    eret();
    exp_src = 8'h00;
    step();

    // ---- 4: masking ----
    wr(3'd2, 32'h01);
    rd(3'd2, 32'h01, "t4_mask");
    exp_src = 8'h01;
    step();
    step();
    chk("t4_masked_a", {31'd0, has_exp}, 32'd0);
    step();
    chk("t4_masked_b", {31'd0, has_exp}, 32'd0);
    rd(3'd4, 32'h01, "t4_pending_kept");
    wr(3'd2, 32'h00);
    chk("t4_unmask_edge", {31'd0, has_exp}, 32'd0);
    step();
    chk("t4_take_after_unmask", {31'd0, has_exp}, 32'd1);
    chk("t4_vec", exc_vector, 32'h0000_0080);
    rd(3'd3, 32'h8000_0000, "t4_cause");
    step();
    eret();
    exp_src = 8'h00;
    step();

    // ---- 5: source rising inside handler, ERET cycle never takes ----
    exp_src = 8'h02;
    step();
    step();
    chk("t5_first_take", {31'd0, has_exp}, 32'd1);
    step();
    exp_src = 8'h42;
    step();
    step();
    chk("t5_no_nested_a", {31'd0, has_exp}, 32'd0);
    step();
    chk("t5_no_nested_b", {31'd0, has_exp}, 32'd0);
    rd(3'd4, 32'h40, "t5_pending");
    eret();
    chk("t5_eret_cycle", {31'd0, has_exp}, 32'd0);
    step();
    chk("t5_take_after_eret", {31'd0, has_exp}, 32'd1);
    chk("t5_vec", exc_vector, 32'h0000_00E0);
    step();
    rd(3'd3, 32'h8000_0006, "t5_cause");
    eret();
    exp_src = 8'h00;
    step();

    // ---- 6: take beats MTC0 EPC; held source pends once ----
    pc_in   = 32'h800;
    exp_src = 8'h10;
    step();
    wr(3'd0, 32'h1234);
    chk("t6_has_exp", {31'd0, has_exp}, 32'd1);
    chk("t6_epc_wins", pc_out, 32'h800);
    repeat (3) step();
    chk("t6_held_once_a", {31'd0, has_exp}, 32'd0);
    eret();
    repeat (3) step();
    chk("t6_held_once_b", {31'd0, has_exp}, 32'd0);
    exp_src = 8'h00;
    step();

    // ---- 1b: reset mid-handler with preloaded registers ----
    wr(3'd2, 32'h80);
    pc_in   = 32'h600;
    exp_src = 8'h81;
    step();
    step();
    chk("t1_take", {31'd0, has_exp}, 32'd1);
    step();
    wr(3'd1, 32'hF0F0_F0F1);
    wr(3'd0, 32'hAAAA);
    rd(3'd4, 32'h80, "t1_preload_pending");
    rd(3'd0, 32'hAAAA, "t1_preload_epc");
    step();
    rst     = 1'b1;
    exp_src = 8'h00;
    #1;
    chk("t1_has_exp", {31'd0, has_exp}, 32'd0);
    chk("t1_exl", {31'd0, exp_block}, 32'd0);
    rd(3'd0, 32'd0, "t1_epc");
    rd(3'd1, 32'd0, "t1_status");
    rd(3'd2, 32'd0, "t1_mask");
    rd(3'd3, 32'd0, "t1_cause");
    rd(3'd4, 32'd0, "t1_pending");
    rst = 1'b0;
    step();
    rd(3'd4, 32'd0, "t1_pending_after");
    // state must be IDLE: a fresh source is taken with normal latency
    pc_in   = 32'h44;
    exp_src = 8'h08;
    step();
    chk("t1_idle_pend", {31'd0, has_exp}, 32'd0);
    step();
    chk("t1_idle_take", {31'd0, has_exp}, 32'd1);
    chk("t1_idle_vec", exc_vector, 32'h0000_00B0);
    chk("t1_idle_epc", pc_out, 32'h44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
Parametrised CP0 exception controller; successor to the 3-source CP0.
- Handles NUM_SRC edge-triggered exception sources with sticky pending bits, a per-source mask, fixed priority (lowest index wins) and vectored handler addresses.
- Fully synchronous, clock-gating-free.
- Sits beside the single-cycle datapath: decodes MTC0/MFC0/ERET from the instruction word, supplies handler PC or EPC to the PC mux, and returns CP0 register data to the writeback mux.

Parameters:
- NUM_SRC, 8, number of exception sources (1..16).
- DATA_W, 32, CP0 register and PC width.
- VEC_BASE, 32'h0000_0080, handler address for source 0.
- VEC_STRIDE, 32'h0000_0010, address step between source handlers.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  CP0 access enable for current instruction
- inst  in  32  current instruction word
- din  in  DATA_W  MTC0 write data (RegFile D2)
- pc_in  in  DATA_W  PC of the instruction to resume at
- exp_src  in  NUM_SRC  raw exception/interrupt sources, level signals
- is_eret  out  1  combinational ERET decode
- ex_reg_write  out  1  combinational MFC0 flag, = ~inst[23]
- has_exp  out  1  one-cycle registered pulse: exception taken
- exp_block  out  1  STATUS[0] (EXL)
- exc_vector  out  DATA_W  handler address, valid while has_exp=1
- pc_out  out  DATA_W  EPC
- dout  out  DATA_W  CP0 read data selected by sel

Behaviour:
Decode:
- is_eret = inst[5:0]==6'b011000.
- sel = inst[13:11].
- cp0_we = enable & inst[23] & ~is_eret.

Registers, by sel:
- 0 EPC: R/W.
- 1 STATUS: bit0 EXL, other bits R/W storage.
- 2 MASK: bits [NUM_SRC-1:0] R/W, 1 = blocked; upper bits read 0.
- 3 CAUSE: RO. [31] valid, [4:0] taken source index.
- 4 PENDING: RO, zero-extended.
- 5..7: read 0, writes ignored.

Reset (async): EPC, STATUS, MASK, CAUSE, PENDING, src_q, has_exp all 0; state IDLE.

Source capture:
- src_q <= exp_src every cycle.
- rise = exp_src & ~src_q.
- PENDING <= (PENDING & ~clr) | rise. Set wins over clear for the same bit in the same cycle.
- A held-high source pends exactly once.

Eligibility and priority:
- elig = PENDING & ~MASK[NUM_SRC-1:0].
- idx = lowest set bit of elig.

FSM states IDLE, TAKE, HANDLER:
- IDLE -> TAKE when |elig & ~EXL. On that edge:
  - EPC <= pc_in
  - CAUSE <= {1'b1, idx}
  - EXL <= 1
  - clr = onehot(idx)
  - has_exp <= 1
  - exc_vector <= VEC_BASE + idx*VEC_STRIDE
- TAKE -> HANDLER unconditionally; has_exp <= 0. has_exp is high exactly one cycle.
- HANDLER -> IDLE on is_eret & enable; EXL <= 0.
- ERET in IDLE: clears EXL only.

Latency:
- Source rising before edge k: pending visible after edge k.
- has_exp high from edge k+1 to edge k+2.

Simultaneous events:
- Exception take beats an MTC0 to EPC/STATUS in the same cycle; that write is dropped.
- An MTC0 setting EXL=1 blocks a take decided in the following cycle, not the same one.
- An ERET cycle never takes an exception; the earliest take is the next cycle.
- Sources rising during TAKE/HANDLER stay pending and are taken after ERET if unmasked.
- A masked pending bit is retained. Unmasking makes it eligible the next cycle.

Width:
- NUM_SRC < DATA_W.
- exc_vector arithmetic is modulo 2^DATA_W.

Reset mid-handler: returns to IDLE immediately and drops all pending bits.

Decomposition:
Shared package cp0_pkg holds:
- CP0 register index constants (SEL_EPC=0, SEL_STATUS=1, SEL_MASK=2, SEL_CAUSE=3, SEL_PENDING=4)
- ERET funct constant 6'b011000
- FSM state encoding

One sub-module, cp0_prio_enc: parametrised lowest-index priority encoder, NUM_SRC in, index plus valid out.

Test Plan:
1. Reset with all registers preloaded nonzero -> all read 0; has_exp=0; state IDLE.
2. NUM_SRC=8, pc_in=0x400, exp_src[3] rises before edge k -> PENDING=0x08 after edge k. After edge k+1: has_exp=1 for one cycle, exc_vector=0xB0, EPC=0x400, CAUSE=0x8000_0003, EXL=1, PENDING=0.
3. exp_src[5] and exp_src[2] rise together -> source 2 taken (CAUSE[4:0]=2), PENDING=0x20 retained. After ERET, source 5 is taken; exc_vector=0xD0.
4. MTC0 MASK=0x01, then exp_src[0] rises -> no has_exp, PENDING=0x01. MTC0 MASK=0 -> has_exp two cycles later, CAUSE[4:0]=0.
5. Source rises during HANDLER -> no second has_exp until ERET. An ERET cycle with eligible pending produces no take; the take occurs in the next cycle.
6. MTC0 EPC=0x1234 in the same cycle an exception is taken -> EPC=pc_in, not 0x1234. A held-high source produces only one has_exp.
